pipe_ctrl: RTL
==============

// Module: pipe_ctrl
// PURPOSE
//   Pipeline stall/flush sequencer for the 6-stage core (pc, if, id, ex, mem, wb).
//   - Merges stall requests from id (load-use), ex (multi-cycle op) and mem (bus wait).
//   - Sequences multi-cycle flushes with a redirect PC on exception or branch redirect.
//   - Watches stall duration and flags a hang (stall timeout).
// PARAMETERS
//   FLUSH_LEN  1    cycles flush is held high per flush request (1..15)
//   STALL_MAX  255  consecutive stall cycles before stall_timeout sets
//   CNT_W      8    stall counter width; STALL_MAX must be <= 2**CNT_W-1
// PORTS
//   clk           in   1              clock; all state updates on rising edge
//   rst           in   1              reset, synchronous, active-low (0 = reset)
//   stallreq_id   in   1              id stage requests stall (load-use hazard)
//   stallreq_ex   in   1              ex stage busy (mul/div in progress)
//   stallreq_mem  in   1              mem stage waiting on data bus
//   flush_req     in   1              exception/redirect; single-cycle strobe
//   flush_pc      in   `InstAddrBus   redirect target; valid with flush_req
//   stall         out  `StallBus      [0]=pc [1]=if [2]=id [3]=ex [4]=mem [5]=wb; 1 = hold
//   flush         out  1              clear all stage registers this cycle
//   new_pc        out  `InstAddrBus   redirect PC; pc register loads it while flush=1
//   stall_cnt     out  CNT_W          consecutive stall cycles, saturating
//   stall_timeout out  1              sticky hang flag
// BEHAVIOUR
//   Reset (rst==0 at edge): state=RUN, stall=0, flush=0, new_pc=0, stall_cnt=0,
//     stall_timeout=0, flush counter=0. Reset mid-flush or mid-stall aborts at once.
//   States
//     RUN    no active stall
//     STALL  at least one request active
//     FLUSH  flush in progress
//   stall output: combinational from state and requests, 0 latency.
//     Priority mem > ex > id:
//     - mem -> 6'b011111
//     - ex  -> 6'b001111
//     - id  -> 6'b000111
//     - none -> 6'b000000
//     In FLUSH, stall=0 and all requests are ignored.
//   flush and new_pc: registered, 1-cycle latency.
//     - flush_req sampled at edge N: flush=1 and new_pc=flush_pc from edge N+1,
//       held for FLUSH_LEN cycles, then state returns to RUN.
//   Transitions, evaluated each edge, first match wins:
//     1. flush_req        -> FLUSH; load new_pc; load flush counter with FLUSH_LEN
//                            (from any state, including FLUSH).
//     2. FLUSH, count>1   -> FLUSH; count decrements.
//     3. FLUSH, count==1  -> RUN; flush drops at the next edge.
//     4. any request high -> STALL.
//     5. otherwise        -> RUN.
//   A flush_req during FLUSH re-latches new_pc and restarts the FLUSH_LEN count.
//   A flush_req in the same cycle as any stall request: flush wins; the stall for
//     that cycle is still driven combinationally.
//   stall_cnt:
//     - +1 on each edge where stall!=0, saturating at 2**CNT_W-1.
//     - Cleared on an edge where stall==0 or when entering FLUSH.
//   stall_timeout:
//     - Set on the edge where stall_cnt reaches STALL_MAX.
//     - Cleared only by reset or by entering FLUSH.
//     - Setting it does not alter stall.
//   flush_pc is ignored when flush_req=0.
// STRUCTURE
//   defines.v additions:
//     - `StallBus 5:0
//     - `StallNone, `StallId, `StallEx, `StallMem encodings
//     - `PcRun, `PcStall, `PcFlush state codes (2 bits)
//   Single module, no sub-modules; the stall priority encoder is an always @(*) block.
// TESTING
//   1. Reset: rst=0 for 3 cycles with all requests high
//      -> stall=0, flush=0, new_pc=0, stall_cnt=0, timeout=0 throughout.
//   2. Priority: id=1 only -> 6'b000111; add ex -> 6'b001111; add mem -> 6'b011111;
//      drop all -> 0, and stall_cnt clears on the next edge.
//   3. Flush, FLUSH_LEN=1: flush_req with flush_pc=32'h0000_0040
//      -> next cycle flush=1, new_pc=32'h40, stall=0; following cycle flush=0, RUN.
//   4. Flush during stall, FLUSH_LEN=3: stallreq_mem=1 held, flush_req pulse
//      -> flush=1 for exactly 3 cycles with stall=0; then stall=6'b011111 again.
//   5. Timeout, STALL_MAX=4: stallreq_ex held 6 cycles
//      -> stall_timeout=1 at the edge where stall_cnt==4 and stays high after
//         release; a later flush_req clears it.
//   6. Mid-flush reset, FLUSH_LEN=3: rst=0 in the 2nd flush cycle
//      -> next edge flush=0, new_pc=0, state RUN.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared widths, stall encodings and state codes for pipe_ctrl
package pipe_ctrl_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int STALL_W     = 6;
  localparam int FCNT_W      = 4;

  typedef logic [STALL_W-1:0] stall_bus_t;
  typedef logic [1:0]         pc_state_t;

  // Bit order: [0]=pc [1]=if [2]=id [3]=ex [4]=mem [5]=wb; a stall holds its stage and all earlier ones
  localparam stall_bus_t STALL_NONE = 6'b000000;
  localparam stall_bus_t STALL_ID   = 6'b000111;
  localparam stall_bus_t STALL_EX   = 6'b001111;
  localparam stall_bus_t STALL_MEM  = 6'b011111;

  localparam pc_state_t PC_RUN   = 2'd0;
  localparam pc_state_t PC_STALL = 2'd1;
  localparam pc_state_t PC_FLUSH = 2'd2;

  function automatic stall_bus_t stall_encode(input logic mem, input logic ex, input logic id);
    if (mem)     return STALL_MEM;
    else if (ex) return STALL_EX;
    else if (id) return STALL_ID;
    else         return STALL_NONE;
  endfunction

endpackage

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush sequencer with stall-hang detection
// Stall is combinational from state and requests; flush/new_pc are registered.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_LEN = 1,
  parameter int STALL_MAX = 255,
  parameter int CNT_W     = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_stallreq_id,
  input  logic                   i_stallreq_ex,
  input  logic                   i_stallreq_mem,
  input  logic                   i_flush_req,
  input  logic [INST_ADDR_W-1:0] i_flush_pc,
  output logic [STALL_W-1:0]     o_stall,
  output logic                   o_flush,
  output logic [INST_ADDR_W-1:0] o_new_pc,
  output logic [CNT_W-1:0]       o_stall_cnt,
  output logic                   o_stall_timeout
);

  localparam logic [FCNT_W-1:0] FLUSH_LEN_L = FCNT_W'(FLUSH_LEN);
  localparam logic [CNT_W-1:0]  STALL_MAX_L = CNT_W'(STALL_MAX);
  localparam logic [CNT_W-1:0]  CNT_SAT     = {CNT_W{1'b1}};

  pc_state_t               r_state;
  logic [FCNT_W-1:0]       r_flush_cnt;
  logic [INST_ADDR_W-1:0]  r_new_pc;
  logic [CNT_W-1:0]        r_stall_cnt;
  logic                    r_timeout;

  stall_bus_t              w_stall;
  logic                    w_any_req;
  logic [CNT_W-1:0]        w_cnt_inc;

  assign w_any_req = i_stallreq_id | i_stallreq_ex | i_stallreq_mem;
  assign w_cnt_inc = (r_stall_cnt == CNT_SAT) ? r_stall_cnt : r_stall_cnt + 1'b1;

  // Held low during reset so no stage is frozen before the state register is valid
  always_comb begin
    w_stall = STALL_NONE;
    if (i_rst && (r_state != PC_FLUSH))
      w_stall = stall_encode(i_stallreq_mem, i_stallreq_ex, i_stallreq_id);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state     <= PC_RUN;
      r_flush_cnt <= '0;
      r_new_pc    <= '0;
      r_stall_cnt <= '0;
      r_timeout   <= 1'b0;
    end else if (i_flush_req) begin
      r_state     <= PC_FLUSH;
      r_flush_cnt <= FLUSH_LEN_L;
      r_new_pc    <= i_flush_pc;
      r_stall_cnt <= '0;
      r_timeout   <= 1'b0;
    end else begin
      if (r_state == PC_FLUSH) begin
        if (r_flush_cnt > 4'd1) begin
          r_flush_cnt <= r_flush_cnt - 4'd1;
        end else begin
          r_state     <= PC_RUN;
          r_flush_cnt <= '0;
        end
      end else if (w_any_req) begin
        r_state <= PC_STALL;
      end else begin
        r_state <= PC_RUN;
      end

      if (w_stall != STALL_NONE) begin
        r_stall_cnt <= w_cnt_inc;
        if (w_cnt_inc == STALL_MAX_L)
          r_timeout <= 1'b1;
      end else begin
        r_stall_cnt <= '0;
      end
    end
  end

  assign o_stall         = w_stall;
  assign o_flush         = (r_state == PC_FLUSH);
  assign o_new_pc        = r_new_pc;
  assign o_stall_cnt     = r_stall_cnt;
  assign o_stall_timeout = r_timeout;

endmodule
